// File: rtl/wash_timer_pkg.sv
// wash_timer_pkg: controller state codes, display codes and BCD helpers shared by the wash timer
package wash_timer_pkg;

   localparam int BCD_W      = 4;
   localparam int BIN_W      = 10;
   localparam int CONV_STEPS = 10;

   localparam logic [2:0] shutDownST = 3'd0;
   localparam logic [2:0] beginST    = 3'd1;
   localparam logic [2:0] setST      = 3'd2;
   localparam logic [2:0] runST      = 3'd3;
   localparam logic [2:0] errorST    = 3'd4;
   localparam logic [2:0] pauseST    = 3'd5;
   localparam logic [2:0] finishST   = 3'd6;

   localparam logic [5:0] showEmpty = 6'd55;
   localparam logic [5:0] showFull  = 6'd56;
   localparam logic [5:0] showPause = 6'd57;
   localparam logic [5:0] showError = 6'd58;

   typedef logic [BCD_W-1:0]   bcd_t;
   typedef logic [3*BCD_W-1:0] bcd3_t;

   // double-dabble correction: any digit of 5 or more gets 3 added before the shift
   function automatic bcd3_t dabble_adj(input bcd3_t b);
      bcd3_t r;
      for (int i = 0; i < 3; i++)
         r[i*BCD_W +: BCD_W] = (b[i*BCD_W +: BCD_W] >= 4'd5) ? b[i*BCD_W +: BCD_W] + 4'd3 : b[i*BCD_W +: BCD_W];
      return r;
   endfunction

   // three BCD digits top out at 999
   function automatic logic [BIN_W-1:0] clamp999(input logic [BIN_W-1:0] v);
      return (v > 10'd999) ? 10'd999 : v;
   endfunction

endpackage

// File: rtl/wash_timer_bin2bcd_seq.sv
// wash_timer_bin2bcd_seq: iterative 10-bit binary to 3-digit BCD converter, one shift per cycle
module wash_timer_bin2bcd_seq
   import wash_timer_pkg::*;
(
   input  logic             cp,
   input  logic             nCR,
   input  logic             start,
   input  logic             abort,
   input  logic [BIN_W-1:0] bin_in,
   output logic             busy,
   output logic             valid,
   output bcd3_t            bcd_out
);

   logic [BIN_W-1:0] bin_q, bin_d;
   bcd3_t            bcd_q, bcd_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             busy_q, busy_d;

   // the first shift happens on start, so the result is complete while busy's last cycle is showing
   always_comb begin
      bin_d  = bin_q;
      bcd_d  = bcd_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (abort)
         busy_d = 1'b0;
      else if (start) begin
         {bcd_d, bin_d} = {12'd0, bin_in} << 1;
         cnt_d          = 4'(CONV_STEPS - 1);
         busy_d         = 1'b1;
      end else if (busy_q) begin
         if (cnt_q == 4'd0)
            busy_d = 1'b0;
         else begin
            {bcd_d, bin_d} = {dabble_adj(bcd_q), bin_q} << 1;
            cnt_d          = cnt_q - 4'd1;
         end
      end
   end

   // converter state registers
   always_ff @(posedge cp or negedge nCR) begin
      if (!nCR) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         bcd_q  <= bcd_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign busy    = busy_q;
   assign valid   = busy_q && (cnt_q == 4'd0) && !start && !abort;
   assign bcd_out = bcd_q;

endmodule

// File: rtl/wash_timer.sv
// wash_timer: 1 Hz timebase plus BCD countdown of the current wash phase; WASH_TIMER_BLANK_EN enables leading-zero blanking
module wash_timer
   import wash_timer_pkg::*;
#(
   parameter int         DIV        = 50000000,
   parameter logic [5:0] CODE_EMPTY = showEmpty
) (
   input  logic       cp,
   input  logic       nCR,
   input  logic [2:0] state,
   input  logic       load,
   input  logic [9:0] loadSec,
   output logic       second,
   output logic       tick,
   output logic       busy,
   output logic       done,
   output logic [5:0] outLeft,
   output logic [5:0] outMiddle,
   output logic [5:0] outRight
);

`ifdef WASH_TIMER_BLANK_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   localparam int PC_W = $clog2(DIV);

   logic [PC_W-1:0] pc_q, pc_d;
   logic            second_q, second_d;
   logic            tick_q, tick_d;
   bcd_t            hun_q, hun_d, ten_q, ten_d, uni_q, uni_d;
   logic            done_q, done_d;
   logic [5:0]      left_q, left_d, mid_q, mid_d, right_q, right_d;
   logic            off, load_acc, conv_valid, conv_busy, dec;
   bcd3_t           conv_bcd;
   logic [9:0]      load_val;

   assign off      = (state == shutDownST);
   assign load_acc = load && !off;
   assign load_val = clamp999(loadSec);

   wash_timer_bin2bcd_seq u_conv (
      .cp      (cp),
      .nCR     (nCR),
      .start   (load_acc),
      .abort   (off),
      .bin_in  (load_val),
      .busy    (conv_busy),
      .valid   (conv_valid),
      .bcd_out (conv_bcd)
   );

   // prescaler: free-running outside shutDown, second tracks the half-period, tick marks the wrap
   always_comb begin
      pc_d     = off ? '0 : (pc_q == PC_W'(DIV - 1)) ? '0 : pc_q + 1'b1;
      second_d = !off && (pc_d < PC_W'(DIV / 2));
      tick_d   = !off && (pc_q == PC_W'(DIV - 1));
   end

   // countdown: a finished conversion beats a decrement, and a pending load suppresses the decrement
   always_comb begin
      hun_d  = hun_q;
      ten_d  = ten_q;
      uni_d  = uni_q;
      done_d = 1'b0;
      dec    = !off && tick_q && (state == runST) && !conv_busy && !load_acc
               && ({hun_q, ten_q, uni_q} != 12'd0);
      if (off)
         {hun_d, ten_d, uni_d} = 12'd0;
      else if (conv_valid)
         {hun_d, ten_d, uni_d} = conv_bcd;
      else if (dec) begin
         uni_d  = (uni_q == 4'd0) ? 4'd9 : uni_q - 4'd1;
         ten_d  = (uni_q != 4'd0) ? ten_q : (ten_q == 4'd0) ? 4'd9 : ten_q - 4'd1;
         hun_d  = (uni_q != 4'd0 || ten_q != 4'd0) ? hun_q : hun_q - 4'd1;
         done_d = (uni_q == 4'd1) && (ten_q == 4'd0) && (hun_q == 4'd0);
      end
   end

   // digit codes for the view stage, optionally blanking leading zeros
   always_comb begin
      left_d  = (BLANK && hun_q == 4'd0) ? CODE_EMPTY : {2'b00, hun_q};
      mid_d   = (BLANK && hun_q == 4'd0 && ten_q == 4'd0) ? CODE_EMPTY : {2'b00, ten_q};
      right_d = {2'b00, uni_q};
   end

   // all timer registers
   always_ff @(posedge cp or negedge nCR) begin
      if (!nCR) begin
         pc_q     <= '0;
         second_q <= 1'b0;
         tick_q   <= 1'b0;
         hun_q    <= '0;
         ten_q    <= '0;
         uni_q    <= '0;
         done_q   <= 1'b0;
         left_q   <= '0;
         mid_q    <= '0;
         right_q  <= '0;
      end else begin
         pc_q     <= pc_d;
         second_q <= second_d;
         tick_q   <= tick_d;
         hun_q    <= hun_d;
         ten_q    <= ten_d;
         uni_q    <= uni_d;
         done_q   <= done_d;
         left_q   <= left_d;
         mid_q    <= mid_d;
         right_q  <= right_d;
      end
   end

   assign second    = second_q;
   assign tick      = tick_q;
   assign busy      = conv_busy;
   assign done      = done_q;
   assign outLeft   = left_q;
   assign outMiddle = mid_q;
   assign outRight  = right_q;

endmodule

// File: tb/tb_wash_timer.sv
// tb_wash_timer: directed and randomized checks of wash_timer against a seconds-level reference model
module tb_wash_timer;

   localparam int DIV = 4;
`ifdef WASH_TIMER_BLANK_EN
   localparam bit BL = 1'b1;
`else
   localparam bit BL = 1'b0;
`endif

   logic       cp = 1'b0;
   logic       nCR = 1'b1;
   logic [2:0] state = 3'd0;
   logic       load = 1'b0;
   logic [9:0] loadSec = 10'd0;
   logic       second, tick, busy, done;
   logic [5:0] outLeft, outMiddle, outRight;

   wash_timer #(.DIV(DIV)) dut (
      .cp        (cp),
      .nCR       (nCR),
      .state     (state),
      .load      (load),
      .loadSec   (loadSec),
      .second    (second),
      .tick      (tick),
      .busy      (busy),
      .done      (done),
      .outLeft   (outLeft),
      .outMiddle (outMiddle),
      .outRight  (outRight)
   );

   always #5 cp = ~cp;

   int checks = 0;
   int errors = 0;

   // reference model: remaining time as a plain integer, conversion as a cycles-left counter
   int m_pc, m_cnt, m_left, m_pend, m_l, m_m, m_r;
   bit m_sec, m_tk, m_done;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 0; m_cnt = 0; m_left = 0; m_pend = 0;
      m_l = 0; m_m = 0; m_r = 0;
      m_sec = 0; m_tk = 0; m_done = 0;
   endtask

   task automatic model_edge();
      bit tk_old;
      tk_old = m_tk;
      m_l = (BL && m_cnt / 100 == 0) ? 55 : m_cnt / 100;
      m_m = (BL && m_cnt / 10 == 0) ? 55 : (m_cnt / 10) % 10;
      m_r = m_cnt % 10;
      m_done = 0;
      if (state == 3'd0) begin
         m_pc = 0; m_sec = 0; m_tk = 0; m_cnt = 0; m_left = 0;
      end else begin
         m_tk  = (m_pc == DIV - 1);
         m_pc  = (m_pc + 1) % DIV;
         m_sec = (m_pc < DIV / 2);
         if (load) begin
            m_pend = (loadSec > 999) ? 999 : int'(loadSec);
            m_left = 10;
         end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_cnt = m_pend;
         end else if (tk_old && state == 3'd3 && m_cnt > 0) begin
            m_cnt--;
            m_done = (m_cnt == 0);
         end
      end
   endtask

   task automatic check_all();
      chk("second", second, m_sec);
      chk("tick", tick, m_tk);
      chk("busy", busy, m_left > 0);
      chk("done", done, m_done);
      chk("outLeft", outLeft, m_l);
      chk("outMiddle", outMiddle, m_m);
      chk("outRight", outRight, m_r);
   endtask

   task automatic cycle();
      @(posedge cp);
      model_edge();
      @(negedge cp);
      check_all();
   endtask

   task automatic do_load(input int v);
      load = 1'b1;
      loadSec = 10'(v);
      cycle();
      load = 1'b0;
   endtask

   initial begin
      int nb, nd, tog;
      logic prev;
      model_reset();
      #1 nCR = 1'b0;
      repeat (2) @(negedge cp);
      chk("rst_second", second, 0);
      chk("rst_tick", tick, 0);
      chk("rst_right", outRight, 0);
      nCR = 1'b1;
      repeat (6) cycle();
      chk("sd_second", second, 0);
      chk("sd_tick", tick, 0);

      state = 3'd2;
      cycle();
      do_load(125);
      nb = busy;
      repeat (10) begin cycle(); nb += busy; end
      chk("busy_len", nb, 10);
      cycle();
      chk("ld125_l", outLeft, 1);
      chk("ld125_m", outMiddle, 2);
      chk("ld125_r", outRight, 5);

      do_load(1000);
      repeat (11) cycle();
      chk("ld1000_l", outLeft, 9);
      chk("ld1000_m", outMiddle, 9);
      chk("ld1000_r", outRight, 9);

      do_load(10);
      repeat (11) cycle();
      state = 3'd3;
      for (int i = 0; i < 12 && outRight != 6'd9; i++) cycle();
      chk("dec_r", outRight, 9);
      chk("dec_m", outMiddle, BL ? 55 : 0);
      nd = 0;
      repeat (60) begin cycle(); nd += done; end
      chk("done_cnt", nd, 1);
      chk("zero_l", outLeft, BL ? 55 : 0);
      chk("zero_r", outRight, 0);

      state = 3'd2;
      do_load(37);
      repeat (11) cycle();
      state = 3'd5;
      tog = 0;
      prev = second;
      repeat (20) begin cycle(); tog += (second != prev); prev = second; end
      chk("pause_toggle", int'(tog >= 8), 1);
      chk("pause_m", outMiddle, 3);
      chk("pause_r", outRight, 7);
      state = 3'd4;
      repeat (8) cycle();
      chk("error_r", outRight, 7);
      state = 3'd3;
      for (int i = 0; i < 10 && outRight != 6'd6; i++) cycle();
      chk("resume_r", outRight, 6);
      chk("resume_m", outMiddle, 3);

      for (int i = 0; i < 8 && !m_tk; i++) cycle();
      chk("tick_found", tick, 1);
      do_load(5);
      repeat (11) cycle();
      chk("coll_r", outRight, 5);
      chk("coll_m", outMiddle, BL ? 55 : 0);

      state = 3'd2;
      do_load(300);
      repeat (3) cycle();
      do_load(42);
      repeat (11) cycle();
      chk("reload_l", outLeft, BL ? 55 : 0);
      chk("reload_m", outMiddle, 4);
      chk("reload_r", outRight, 2);

      do_load(500);
      cycle();
      state = 3'd0;
      cycle();
      chk("abort_busy", busy, 0);
      cycle();
      chk("abort_m", outMiddle, BL ? 55 : 0);
      chk("abort_r", outRight, 0);

      state = 3'd2;
      do_load(200);
      repeat (11) cycle();
      state = 3'd3;
      repeat (5) cycle();
      #2 nCR = 1'b0;
      #1;
      chk("arst_left", outLeft, 0);
      chk("arst_busy", busy, 0);
      chk("arst_second", second, 0);
      chk("arst_tick", tick, 0);
      model_reset();
      @(negedge cp);
      state = 3'd0;
      nCR = 1'b1;
      repeat (4) cycle();

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0)
            state = ($urandom_range(0, 9) == 0) ? 3'd0 : 3'($urandom_range(1, 6));
         if (i < 5) state = 3'd3;
         load = ($urandom_range(0, 14) == 0);
         loadSec = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 20));
         cycle();
      end
      load = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
